// File: rtl/fixed_int26_6_accumulate_if.sv
// Ready/Data/Stop channel bundle for the 26.6 accumulator: go/done passthrough,
// term-count command, product stream and sum result.
interface fixed_int26_6_accumulate_if #(
    parameter int unsigned LEN_WIDTH = 16
);
    logic                 goValid;
    logic                 goStop;
    logic                 doneValid;
    logic                 doneStop;
    logic                 lengthReady;
    logic [LEN_WIDTH-1:0] lengthData;
    logic                 lengthStop;
    logic                 termsReady;
    logic [31:0]          termsData;
    logic                 termsStop;
    logic                 sumReady;
    logic [31:0]          sumData;
    logic                 sumOverflow;
    logic                 sumStop;

    modport master (
        output goValid, doneStop, lengthReady, lengthData, termsReady, termsData, sumStop,
        input  goStop, doneValid, lengthStop, termsStop, sumReady, sumData, sumOverflow
    );

    modport slave (
        input  goValid, doneStop, lengthReady, lengthData, termsReady, termsData, sumStop,
        output goStop, doneValid, lengthStop, termsStop, sumReady, sumData, sumOverflow
    );
endinterface

// File: rtl/fixed_int26_6_accumulate.sv
// Sums a commanded number of signed 26.6 products into a wide accumulator and
// emits one 26.6 sum with an out-of-range flag. FIXED_ACC_SATURATE_EN clamps the sum.
module fixed_int26_6_accumulate #(
    parameter int unsigned LEN_WIDTH = 16,
    parameter int unsigned ACC_WIDTH = 48   // must be >= 32 + LEN_WIDTH so the sum cannot wrap
) (
    input  logic                        clk,
    input  logic                        srst,
    fixed_int26_6_accumulate_if.slave   bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned EXT_W  = ACC_WIDTH - DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [LEN_WIDTH-1:0]   count_q, count_d;
    logic [DATA_W-1:0]      sum_data_q, sum_data_d;
    logic                   sum_ovf_q, sum_ovf_d;

    logic [ACC_WIDTH-1:0]   term_ext;
    logic [ACC_WIDTH-1:0]   acc_sum;
    logic [EXT_W:0]         acc_upper;
    logic                   acc_out_of_range;
    logic [DATA_W-1:0]      acc_result;

    assign bus.doneValid = bus.goValid;
    assign bus.goStop    = bus.doneStop;

    // Stops and result valid are decoded from registered state only.
    assign bus.lengthStop  = (state_q != ST_IDLE);
    assign bus.termsStop   = (state_q != ST_ACCUM);
    assign bus.sumReady    = (state_q == ST_OUTPUT);
    assign bus.sumData     = sum_data_q;
    assign bus.sumOverflow = sum_ovf_q;

    // Running sum including the term on offer, and its 32-bit presentation.
    always_comb begin
        term_ext         = {{EXT_W{bus.termsData[DATA_W-1]}}, bus.termsData};
        acc_sum          = acc_q + term_ext;
        acc_upper        = acc_sum[ACC_WIDTH-1:DATA_W-1];
        acc_out_of_range = !((&acc_upper) || !(|acc_upper));
`ifdef FIXED_ACC_SATURATE_EN
        if (acc_out_of_range) begin
            acc_result = acc_sum[ACC_WIDTH-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            acc_result = acc_sum[DATA_W-1:0];
        end
`else
        acc_result = acc_sum[DATA_W-1:0];
`endif
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            sum_data_q <= '0;
            sum_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            sum_data_q <= sum_data_d;
            sum_ovf_q  <= sum_ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        sum_data_d = sum_data_q;
        sum_ovf_d  = sum_ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.lengthReady) begin
                    acc_d   = '0;
                    count_d = bus.lengthData;
                    if (bus.lengthData == '0) begin
                        state_d    = ST_OUTPUT;
                        sum_data_d = '0;
                        sum_ovf_d  = 1'b0;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (bus.termsReady) begin
                    acc_d   = acc_sum;
                    count_d = count_q - LEN_WIDTH'(1);
                    if (count_q == LEN_WIDTH'(1)) begin
                        state_d    = ST_OUTPUT;
                        sum_data_d = acc_result;
                        sum_ovf_d  = acc_out_of_range;
                    end
                end
            end
            ST_OUTPUT: begin
                if (!bus.sumStop) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end
endmodule
